// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: opcode encodings, resp_flags bit
// positions, the output-register FSM state type and the combinational ALU itself.
package alu_share_arbiter_pkg;

    // ALU opcode encodings; any other value is an undefined op (result 0, Zero=1).
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_XOR  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // Bit positions inside resp_flags = {Zero, Overflow, Negative, Carry}.
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_Z = 3;

    typedef enum logic [0:0] {
        StEmpty,
        StFull
    } arb_state_e;

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  flags;
    } alu_out_t;

    // Carry on SUB is the borrow (a < b unsigned), so equal operands give C=0.
    function automatic alu_out_t alu_eval(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        alu_out_t   res;
        logic [32:0] sum;
        logic [31:0] r;
        logic        c;
        logic        v;
        sum = '0;
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            ALU_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[31:0];
                c   = sum[32];
                v   = (a[31] == b[31]) && (r[31] != a[31]);
            end
            ALU_SUB: begin
                sum = {1'b0, a} - {1'b0, b};
                r   = sum[31:0];
                c   = sum[32];
                v   = (a[31] != b[31]) && (r[31] != a[31]);
            end
            ALU_XOR:  r = a ^ b;
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLTU: r = {31'b0, (a < b)};
            default:  r = '0;
        endcase
        res.result         = r;
        res.flags          = '0;
        res.flags[FLAG_Z]  = (r == 32'd0);
        res.flags[FLAG_V]  = v;
        res.flags[FLAG_N]  = r[31];
        res.flags[FLAG_C]  = c;
        return res;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bus bundle between the requesters/consumer (master) and the ALU share arbiter (slave).
//   req_valid/req_ready  per-requester handshake; req_op/a/b sliced per requester
//   resp_*               registered tagged result with valid/ready backpressure
//   sticky_ovf/clr       per-requester sticky overflow and its clear
interface alu_share_arbiter_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [4*NREQ-1:0]  req_op;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [31:0]        resp_result;
    logic [3:0]         resp_flags;
    logic [NREQ-1:0]    sticky_ovf;
    logic [NREQ-1:0]    sticky_clr;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready, sticky_clr,
        input  req_ready, resp_valid, resp_id, resp_result, resp_flags, sticky_ovf
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready, sticky_clr,
        output req_ready, resp_valid, resp_id, resp_result, resp_flags, sticky_ovf
    );
endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin priority select (the rr_arbiter): grants the first set req bit found
// searching upward from ptr with wrap-around. Purely combinational.
//   req_i  request vector      ptr_i  highest-priority index
//   gnt_o  one-hot grant       idx_o  encoded grant index (0 when no request)
module alu_share_arbiter_rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);
    logic          found;
    int unsigned   cand;
    logic [IW-1:0] cand_idx;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(ptr_i) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IW'(cand);
            if (!found && req_i[cand_idx]) begin
                found           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NREQ requesters. A round-robin arbiter picks one
// valid request per cycle whenever the single output register is free (or draining), and
// the ALU result, flags and requester id are captured there and held under backpressure.
//   clk, rst_n   clock and asynchronous active-low reset
//   bus (slave)  request handshakes, tagged response, sticky overflow bits
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus
);
    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [31:0]     result_q, result_d;
    logic [3:0]      flags_q, flags_d;
    logic [NREQ-1:0] sticky_q, sticky_d;

    logic [NREQ-1:0] grant_oh;
    logic [IDW-1:0]  grant_idx;
    logic            slot_free;
    logic            fire;
    logic [3:0]      op_sel;
    logic [31:0]     a_sel;
    logic [31:0]     b_sel;
    alu_out_t        alu_res;

    alu_share_arbiter_rr_arbiter #(
        .N  (NREQ),
        .IW (IDW)
    ) u_rr_arbiter (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (grant_oh),
        .idx_o (grant_idx)
    );

    // A draining consumer frees the slot in the same cycle, giving one result per cycle.
    assign slot_free     = (state_q == StEmpty) || bus.resp_ready;
    assign bus.req_ready = (slot_free && rst_n) ? grant_oh : '0;
    assign fire          = |bus.req_ready;

    always_comb begin
        op_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                op_sel = bus.req_op[4*i +: 4];
                a_sel  = bus.req_a[32*i +: 32];
                b_sel  = bus.req_b[32*i +: 32];
            end
        end
        alu_res = alu_eval(op_sel, a_sel, b_sel);
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        result_d = result_q;
        flags_d  = flags_q;
        // Set beats clear: the clear is applied first, the set below overrides it.
        sticky_d = sticky_q & ~bus.sticky_clr;
        if (fire) begin
            state_d  = StFull;
            id_d     = grant_idx;
            result_d = alu_res.result;
            flags_d  = alu_res.flags;
            ptr_d    = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            if (((op_sel == ALU_ADD) || (op_sel == ALU_SUB)) && alu_res.flags[FLAG_V]) begin
                sticky_d[grant_idx] = 1'b1;
            end
        end else if ((state_q == StFull) && bus.resp_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StEmpty;
            ptr_q    <= '0;
            id_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
            sticky_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.resp_valid  = (state_q == StFull);
    assign bus.resp_id     = id_q;
    assign bus.resp_result = result_q;
    assign bus.resp_flags  = flags_q;
    assign bus.sticky_ovf  = sticky_q;
endmodule
